apb_i2s_csr: RTL and testbench

APB_I2S_CSR -- requirements
Module: apb_i2s_csr

---
 rtl/apb_i2s_csr.sv | 163 ++++++++++++++++
 tb/tb_apb_i2s_csr.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2s_csr.sv
// APB register block for an I2S transmitter: control/status/interrupt CSRs plus one
// TX sample FIFO per channel, popped in lock-step by the serializer.
module apb_i2s_csr #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [ADDR_W-1:0]      PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic                   i2s_en,
    output logic [N_CH*DATA_W-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   tx_pop,
    input  logic                   tx_done,
    output logic                   irq
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0]  wr_ptr_q [N_CH];
    logic [PTR_W-1:0]  wr_ptr_d [N_CH];
    logic [PTR_W-1:0]  rd_ptr_q [N_CH];
    logic [PTR_W-1:0]  rd_ptr_d [N_CH];
    logic [DATA_W-1:0] mem_q    [N_CH][FIFO_DEPTH];

    logic [N_CH-1:0] empty, full, push_req, push;
    logic            en_q, en_d;
    logic [2:0]      ier_q, ier_d, isr_q, isr_d;
    logic            irq_q;

    logic            access, wr_ok, addr_err;
    logic            sel_cr, sel_sr, sel_ier, sel_isr, sel_tx;
    int unsigned     word, tx_idx;
    logic            pop, overflow, underflow, flush;
    logic [PTR_W-1:0] level0;
    logic [31:0]     sr, rdata;

    logic unused_bits;
    assign unused_bits = ^{PWDATA, PADDR[1:0]};

    // Address decode; the two low address bits are ignored.
    always_comb begin
        access   = PSEL & PENABLE;
        word     = 32'(PADDR[ADDR_W-1:2]);
        sel_cr   = (word == 32'd0);
        sel_sr   = (word == 32'd1);
        sel_ier  = (word == 32'd2);
        sel_isr  = (word == 32'd3);
        sel_tx   = (word >= 32'd4) && (word < 32'd4 + N_CH);
        tx_idx   = word - 32'd4;
        addr_err = !(sel_cr | sel_sr | sel_ier | sel_isr | sel_tx) | (sel_sr & PWRITE);
        wr_ok    = access & PWRITE & ~addr_err;
    end

    // FIFO status and transfer qualification.
    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            empty[k]    = (wr_ptr_q[k] == rd_ptr_q[k]);
            full[k]     = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                          (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
        end
        tx_valid  = en_q & ~|empty;
        pop       = tx_pop & tx_valid;
        underflow = tx_pop & ~tx_valid & en_q;
        flush     = wr_ok & sel_cr & PWDATA[1];
        for (int unsigned k = 0; k < N_CH; k++) begin
            push_req[k] = wr_ok & sel_tx & (tx_idx == k);
            // A full FIFO still accepts a push when the head leaves in the same cycle.
            push[k]     = push_req[k] & (~full[k] | pop);
        end
        overflow = |(push_req & full) & ~pop;
    end

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(push[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(pop);
            if (flush) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            tx_data[k*DATA_W +: DATA_W] = mem_q[k][rd_ptr_q[k][AW-1:0]];
        end
    end

    // CSR next state; hardware sets are applied after the W1C so they win a race.
    always_comb begin
        en_d  = en_q;
        ier_d = ier_q;
        isr_d = isr_q;
        if (wr_ok && sel_cr)  en_d  = PWDATA[0];
        if (wr_ok && sel_ier) ier_d = PWDATA[2:0];
        if (wr_ok && sel_isr) isr_d = isr_q & ~PWDATA[2:0];
        isr_d = isr_d | {overflow, underflow, tx_done};
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en_q  <= 1'b0;
            ier_q <= '0;
            isr_q <= '0;
            irq_q <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[k][i] <= '0;
                end
            end
        end else begin
            en_q  <= en_d;
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= |(isr_q & ier_q);
            for (int unsigned k = 0; k < N_CH; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                if (push[k]) begin
                    mem_q[k][wr_ptr_q[k][AW-1:0]] <= PWDATA[DATA_W-1:0];
                end
            end
        end
    end

    // Read mux and status word.
    always_comb begin
        level0 = wr_ptr_q[0] - rd_ptr_q[0];
        sr     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            sr[2*k]   = empty[k];
            sr[2*k+1] = full[k];
        end
        sr[19:16] = 4'(level0);
        rdata = '0;
        if (sel_cr)  rdata = {31'd0, en_q};
        if (sel_sr)  rdata = sr;
        if (sel_ier) rdata = {29'd0, ier_q};
        if (sel_isr) rdata = {29'd0, isr_q};
    end

    // Bus outputs are forced low while reset is asserted, independent of the clock.
    assign PRDATA  = (access && !PWRITE && !addr_err && PRESETn) ? rdata : 32'd0;
    assign PSLVERR = access & addr_err & PRESETn;
    assign PREADY  = 1'b1;
    assign i2s_en  = en_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_apb_i2s_csr.sv
// Self-checking bench for apb_i2s_csr: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_apb_i2s_csr;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int N_CH       = 2;
    localparam int ADDR_W     = 6;

    logic                   PCLK = 1'b0;
    logic                   PRESETn;
    logic                   PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [31:0]            PWDATA, PRDATA;
    logic                   PREADY, PSLVERR;
    logic                   i2s_en, tx_valid, tx_pop, tx_done, irq;
    logic [N_CH*DATA_W-1:0] tx_data;

    apb_i2s_csr #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .N_CH(N_CH), .ADDR_W(ADDR_W)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .i2s_en(i2s_en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_pop(tx_pop), .tx_done(tx_done), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // Reference model state.
    logic [DATA_W-1:0] mq [N_CH][$];
    bit                m_en;
    bit [2:0]          m_ier, m_isr;
    bit                m_irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]            exp_rdata, obs_rdata;
    logic                   exp_err, obs_err, exp_irq, obs_irq, exp_valid, obs_valid;
    logic [N_CH*DATA_W-1:0] exp_data, obs_data;

    function automatic logic [31:0] model_sr();
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < N_CH; k++) begin
            s[2*k]   = (mq[k].size() == 0);
            s[2*k+1] = (mq[k].size() == FIFO_DEPTH);
        end
        s[19:16] = 4'(mq[0].size());
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) mq[k].delete();
        m_en  = 0;
        m_ier = 0;
        m_isr = 0;
        m_irq = 0;
    endtask

    // One APB access (setup + access cycle) with optional pop/done in the access cycle.
    // Starts and ends just after a falling edge; captures outputs mid access phase.
    task automatic xfer(input bit w, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                        input bit pop, input bit done);
        int word;
        bit valid, err, uf, of;
        word  = int'(addr) >> 2;
        valid = m_en;
        for (int k = 0; k < N_CH; k++) if (mq[k].size() == 0) valid = 0;
        err       = !(word < 4 + N_CH) || (w && word == 1);
        exp_err   = err;
        exp_irq   = m_irq;
        exp_valid = valid;
        exp_data  = '0;
        for (int k = 0; k < N_CH; k++)
            if (mq[k].size() > 0) exp_data[k*DATA_W +: DATA_W] = mq[k][0];
        exp_rdata = '0;
        if (!w && !err) begin
            case (word)
                0:       exp_rdata = {31'd0, m_en};
                1:       exp_rdata = model_sr();
                2:       exp_rdata = {29'd0, m_ier};
                3:       exp_rdata = {29'd0, m_isr};
                default: exp_rdata = '0;
            endcase
        end

        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1; tx_pop = pop; tx_done = done;
        #1;
        obs_rdata = PRDATA; obs_err = PSLVERR; obs_irq = irq;
        obs_valid = tx_valid; obs_data = tx_data;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0; PWRITE = 0; tx_pop = 0; tx_done = 0;

        uf = pop && !valid && m_en;
        of = 0;
        if (pop && valid) for (int k = 0; k < N_CH; k++) void'(mq[k].pop_front());
        if (w && !err && word >= 4) begin
            if (mq[word-4].size() < FIFO_DEPTH) mq[word-4].push_back(data[DATA_W-1:0]);
            else of = 1;
        end
        if (w && !err && word == 0) begin
            m_en = data[0];
            if (data[1]) for (int k = 0; k < N_CH; k++) mq[k].delete();
        end
        if (w && !err && word == 2) m_ier = data[2:0];
        if (w && !err && word == 3) m_isr = m_isr & ~data[2:0];
        m_isr = m_isr | {of, uf, done};
        m_irq = |(m_isr & m_ier);
    endtask

    task automatic test_reset();
        PRESETn = 0;
        #3;
        PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 6'h04;
        #1;
        n_checks++;
        if (PRDATA !== 32'd0 || PSLVERR !== 1'b0) $display("FAIL reset_bus: PRDATA=%h PSLVERR=%b want 0/0", PRDATA, PSLVERR);
        else n_pass++;
        n_checks++;
        if ({irq, tx_valid, i2s_en} !== 3'b000) $display("FAIL reset_outs: irq/valid/en=%b want 000", {irq, tx_valid, i2s_en});
        else n_pass++;
        PSEL = 0; PENABLE = 0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        model_reset();
        xfer(0, 6'h04, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h0000_0005) $display("FAIL reset_sr: got %h want 00000005", obs_rdata);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 9; i++) xfer(1, 6'h10, 32'h100 + i, 0, 0);
        xfer(0, 6'h04, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h0008_0006) $display("FAIL fill_sr: got %h want 00080006", obs_rdata);
        else n_pass++;
        xfer(0, 6'h0C, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h4) $display("FAIL fill_isr: got %h want 4", obs_rdata);
        else n_pass++;
        xfer(1, 6'h08, 32'h4, 0, 0);
        xfer(0, 6'h0C, 0, 0, 0);
        n_checks++;
        if (obs_irq !== 1'b1) $display("FAIL fill_irq: got %b want 1", obs_irq);
        else n_pass++;
        xfer(1, 6'h0C, 32'h4, 0, 0);
        xfer(0, 6'h0C, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h0 || obs_irq !== 1'b0) $display("FAIL fill_w1c: isr=%h irq=%b want 0/0", obs_rdata, obs_irq);
        else n_pass++;
        xfer(1, 6'h00, 32'h2, 0, 0);
        xfer(1, 6'h08, 32'h0, 0, 0);
    endtask

    task automatic test_frame_pop();
        xfer(1, 6'h10, 32'hA5A5, 0, 0);
        xfer(1, 6'h14, 32'h5A5A, 0, 0);
        xfer(1, 6'h00, 32'h1, 0, 0);
        xfer(0, 6'h00, 0, 1, 0);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_data !== 64'h0000_5A5A_0000_A5A5)
            $display("FAIL frame_head: valid=%b data=%h want 1/00005a5a0000a5a5", obs_valid, obs_data);
        else n_pass++;
        xfer(0, 6'h04, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h5 || obs_valid !== 1'b0) $display("FAIL frame_empty: sr=%h valid=%b want 5/0", obs_rdata, obs_valid);
        else n_pass++;
        xfer(0, 6'h00, 0, 1, 0);
        xfer(0, 6'h0C, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h2) $display("FAIL frame_underflow: isr=%h want 2", obs_rdata);
        else n_pass++;
        xfer(1, 6'h0C, 32'h7, 0, 0);
        xfer(1, 6'h00, 32'h0, 0, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            xfer(1, 6'h10, $urandom, 0, 0);
            xfer(1, 6'h14, $urandom, 0, 0);
        end
        xfer(1, 6'h00, 32'h1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            xfer(1, 6'h10, $urandom, 1, 0);
            n_checks++;
            if (obs_valid !== 1'b1 || obs_data !== exp_data)
                $display("FAIL wrap_order[%0d]: valid=%b data=%h want 1/%h", i, obs_valid, obs_data, exp_data);
            else n_pass++;
            xfer(1, 6'h14, $urandom, 0, 0);
            xfer(0, 6'h04, 0, 0, 0);
            n_checks++;
            if (obs_rdata !== 32'h0008_000A) $display("FAIL wrap_level[%0d]: sr=%h want 0008000a", i, obs_rdata);
            else n_pass++;
        end
        xfer(0, 6'h0C, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h0) $display("FAIL wrap_isr: got %h want 0", obs_rdata);
        else n_pass++;
        xfer(1, 6'h00, 32'h2, 0, 0);
    endtask

    task automatic test_flush_errors();
        for (int i = 0; i < 3; i++) xfer(1, 6'h10, $urandom, 0, 0);
        for (int i = 0; i < 2; i++) xfer(1, 6'h14, $urandom, 0, 0);
        xfer(1, 6'h00, 32'h3, 0, 0);
        xfer(0, 6'h04, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h5) $display("FAIL flush_sr: got %h want 5", obs_rdata);
        else n_pass++;
        xfer(0, 6'h00, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h1) $display("FAIL flush_cr: got %h want 1", obs_rdata);
        else n_pass++;
        xfer(0, 6'h3C, 0, 0, 0);
        n_checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'h0) $display("FAIL err_read: err=%b data=%h want 1/0", obs_err, obs_rdata);
        else n_pass++;
        xfer(1, 6'h3C, 32'hFFFF_FFFF, 0, 0);
        n_checks++;
        if (obs_err !== 1'b1) $display("FAIL err_write: err=%b want 1", obs_err);
        else n_pass++;
        xfer(1, 6'h04, 32'hFFFF_FFFF, 0, 0);
        n_checks++;
        if (obs_err !== 1'b1) $display("FAIL err_sr_write: err=%b want 1", obs_err);
        else n_pass++;
        xfer(0, 6'h10, 0, 0, 0);
        n_checks++;
        if (obs_err !== 1'b0 || obs_rdata !== 32'h0) $display("FAIL txdata_read: err=%b data=%h want 0/0", obs_err, obs_rdata);
        else n_pass++;
        xfer(0, 6'h18, 0, 0, 0);
        n_checks++;
        if (obs_err !== 1'b1) $display("FAIL err_txdata2: err=%b want 1", obs_err);
        else n_pass++;
        xfer(1, 6'h00, 32'h0, 0, 0);
    endtask

    task automatic test_race();
        xfer(1, 6'h0C, 32'h7, 0, 0);
        xfer(1, 6'h0C, 32'h1, 0, 1);
        xfer(0, 6'h0C, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h1) $display("FAIL race_isr: got %h want 1", obs_rdata);
        else n_pass++;
        xfer(1, 6'h0C, 32'h7, 0, 0);
    endtask

    task automatic test_random();
        int r;
        logic [ADDR_W-1:0] a;
        logic [31:0] d;
        bit w;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 6'(r * 4);
            else if (r == 7) a = 6'h3C;
            else             a = 6'(16 + 4 * (r - 8));
            a = a | 6'($urandom_range(0, 3));
            w = (r >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            d = $urandom;
            if ((a >> 2) == 0) d = {30'd0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0)};
            xfer(w, a, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            n_checks++;
            if (obs_err !== exp_err || obs_rdata !== exp_rdata)
                $display("FAIL rnd_bus[%0d]: err=%b data=%h want %b/%h", i, obs_err, obs_rdata, exp_err, exp_rdata);
            else n_pass++;
            n_checks++;
            if (obs_irq !== exp_irq || obs_valid !== exp_valid)
                $display("FAIL rnd_flags[%0d]: irq=%b valid=%b want %b/%b", i, obs_irq, obs_valid, exp_irq, exp_valid);
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (obs_data !== exp_data) $display("FAIL rnd_data[%0d]: got %h want %h", i, obs_data, exp_data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        xfer(1, 6'h10, 32'h1111, 0, 0);
        xfer(1, 6'h14, 32'h2222, 0, 0);
        xfer(1, 6'h00, 32'h1, 0, 0);
        #2;
        PRESETn = 0;
        #1;
        n_checks++;
        if ({tx_valid, i2s_en, irq} !== 3'b000) $display("FAIL midreset_outs: valid/en/irq=%b want 000", {tx_valid, i2s_en, irq});
        else n_pass++;
        @(negedge PCLK);
        PRESETn = 1;
        model_reset();
        xfer(0, 6'h04, 0, 0, 0);
        n_checks++;
        if (obs_rdata !== 32'h5 || obs_valid !== 1'b0) $display("FAIL midreset_sr: sr=%h valid=%b want 5/0", obs_rdata, obs_valid);
        else n_pass++;
    endtask

    initial begin
        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        tx_pop = 0; tx_done = 0;
        test_reset();
        test_fill();
        test_frame_pop();
        test_wrap();
        test_flush_errors();
        test_race();
        test_random();
        test_reset_mid();
        n_checks++;
        if (PREADY !== 1'b1) $display("FAIL pready: got %b want 1", PREADY);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
